input_debounce: RTL

//  Conditions the 14 raw switch/button inputs before they reach the OR/LED logic stage.
//  Per channel: 2-flop synchronizer, then a stability counter that accepts a new level

---
 rtl/input_debounce_pkg.sv | 21 ++
 rtl/debounce_channel.sv | 77 +++++++
 rtl/input_debounce.sv | 63 ++++++
 3 files changed

// File: rtl/input_debounce_pkg.sv
// ============================================================================
// Module      : input_debounce_pkg
// Description : Default parameters and width helper shared by the debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package input_debounce_pkg;

    localparam int DEF_WIDTH        = 14;
    localparam int DEF_TICK_DIV     = 1;
    localparam int DEF_STABLE_TICKS = 4;

    // $clog2 returns 0 for 1; every counter needs at least one bit.
    function automatic int clog2_min1(input int value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_channel.sv
// ============================================================================
// Module      : debounce_channel
// Description : One channel: 2-flop synchronizer, tick-based stability counter,
//               registered debounced level and one-cycle edge pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module debounce_channel
    import input_debounce_pkg::*;
#(
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    input  logic tick,
    output logic db,
    output logic rise,
    output logic fall
);

    localparam int              CW         = clog2_min1(STABLE_TICKS);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(STABLE_TICKS - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          db_q,   db_d;
    logic          rise_q, rise_d;
    logic          fall_q, fall_d;
    logic [CW-1:0] cnt_q,  cnt_d;

    always_comb begin
        cnt_d  = cnt_q;
        db_d   = db_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        // Any agreement with the accepted level throws away partial progress.
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (tick) begin
            if (cnt_q >= C_CNT_LAST) begin
                db_d   = sync2_q;
                cnt_d  = '0;
                rise_d = sync2_q;
                fall_d = ~sync2_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= raw;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            cnt_q   <= cnt_d;
        end
    end

    assign db   = db_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

`default_nettype wire

// File: rtl/input_debounce.sv
// ============================================================================
// Module      : input_debounce
// Description : WIDTH-channel switch debouncer with shared tick prescaler and
//               per-channel rise/fall pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int WIDTH        = DEF_WIDTH,
    parameter int TICK_DIV     = DEF_TICK_DIV,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] raw_in,
    output logic [WIDTH-1:0] db_out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             any_change
);

    localparam int            PW         = clog2_min1(TICK_DIV);
    localparam logic [PW-1:0] C_PRE_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] pre_q, pre_d;
    logic          tick;

    // Tick is decoded from the register so every channel sees a glitch-free strobe.
    assign tick  = (pre_q == C_PRE_LAST);
    assign pre_d = tick ? '0 : pre_q + PW'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_ch
            debounce_channel #(
                .STABLE_TICKS (STABLE_TICKS)
            ) u_ch (
                .clk  (clk),
                .rst  (rst),
                .raw  (raw_in[i]),
                .tick (tick),
                .db   (db_out[i]),
                .rise (rise[i]),
                .fall (fall[i])
            );
        end
    endgenerate

    assign any_change = |(rise | fall);

endmodule

`default_nettype wire
